bram_lsu_bridge: RTL and testbench

//  Load/store bridge between the core's valid/ready memory request channel and data-BRAM port B.

---
 rtl/bram_lsu_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_bram_lsu_bridge.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_lsu_bridge.sv
// Load/store bridge between the core's valid/ready request channel and data-BRAM port B.
// Turns byte/half/word accesses into word-aligned BRAM cycles and returns one response per request.
module bram_lsu_bridge #(
  parameter int unsigned MEM_BYTES  = 262144,
  parameter int unsigned RD_LATENCY = 1       // 1 or 2 clkb edges after the enb edge
) (
  input  logic        clkb,
  input  logic        rstb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        enb,
  output logic [3:0]  web,
  output logic [31:0] addrb,
  output logic [31:0] dinb,
  input  logic [31:0] doutb,
  input  logic        rstb_busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a request or response transfers on a rising edge where valid and ready
  // are both high; a raised rsp_valid keeps its payload stable until that edge.

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_ISSUE = 2'd1;
  localparam logic [1:0]  ST_WAIT  = 2'd2;
  localparam logic [1:0]  ST_RESP  = 2'd3;
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
  localparam logic [1:0]  CNT_INIT  = 2'(RD_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic        enb_q, enb_d;
  logic [3:0]  web_q, web_d;
  logic [31:0] addrb_q, addrb_d;
  logic [31:0] dinb_q, dinb_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        req_bad;
  logic [3:0]  web_n;
  logic [31:0] dinb_n;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;

  assign req_ready = (state_q == ST_IDLE) & ~rstb & ~rstb_busy;

  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = (req_addr[1:0] != 2'b00);
      2'b11:   req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
    if ({1'b0, req_addr} >= MEM_LIMIT) begin
      req_bad = 1'b1;
    end
  end

  // Store data is replicated across every lane so the strobes alone pick the target bytes.
  always_comb begin
    web_n  = 4'b1111;
    dinb_n = req_wdata;
    case (req_size)
      2'b00: begin
        web_n  = 4'b0001 << req_addr[1:0];
        dinb_n = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        web_n  = 4'b0011 << req_addr[1:0];
        dinb_n = {2{req_wdata[15:0]}};
      end
      default: begin
        web_n  = 4'b1111;
        dinb_n = req_wdata;
      end
    endcase
    if (!req_we) begin
      web_n = 4'b0000;
    end
  end

  always_comb begin
    lane_b = doutb[7:0];
    case (off_q)
      2'd1:    lane_b = doutb[15:8];
      2'd2:    lane_b = doutb[23:16];
      2'd3:    lane_b = doutb[31:24];
      default: lane_b = doutb[7:0];
    endcase
    // Halfwords are aligned, so only offsets 0 and 2 reach here.
    lane_h = off_q[1] ? doutb[31:16] : doutb[15:0];
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_data = doutb;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    enb_d       = 1'b0;
    web_d       = 4'b0000;
    addrb_d     = addrb_q;
    dinb_d      = dinb_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if (req_bad) begin
            // Errors answer directly; the BRAM never sees them.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            enb_d   = 1'b1;
            web_d   = web_n;
            addrb_d = {req_addr[31:2], 2'b00};
            dinb_d  = dinb_n;
            we_d    = req_we;
            size_d  = req_size;
            uns_d   = req_unsigned;
            off_d   = req_addr[1:0];
          end
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkb) begin
    if (rstb) begin
      state_q     <= ST_IDLE;
      enb_q       <= 1'b0;
      web_q       <= 4'b0000;
      addrb_q     <= 32'h0;
      dinb_q      <= 32'h0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      cnt_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      enb_q       <= enb_d;
      web_q       <= web_d;
      addrb_q     <= addrb_d;
      dinb_q      <= dinb_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign enb       = enb_q;
  assign web       = web_q;
  assign addrb     = addrb_q;
  assign dinb      = dinb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bram_lsu_bridge.sv
// Bench for bram_lsu_bridge: one instance per read latency (1 and 2), each with its own BRAM model.
module tb_bram_lsu_bridge;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam int         TIMEOUT = 20;

  logic        clkb = 1'b0;
  logic        rstb = 1'b1;
  logic        rstb_busy = 1'b0;
  logic        rsp_ready = 1'b1;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        enb       [2];
  logic [3:0]  web       [2];
  logic [31:0] addrb     [2];
  logic [31:0] dinb      [2];
  logic [31:0] doutb     [2];
  logic [1:0]  dbg_state [2];

  logic [32:0] exp_q [$];
  logic [7:0]  ref_mem [2][1024];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clkb = ~clkb;

  bram_lsu_bridge #(.MEM_BYTES(262144), .RD_LATENCY(1)) u_dut0 (
    .clkb(clkb), .rstb(rstb), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .enb(enb[0]), .web(web[0]), .addrb(addrb[0]), .dinb(dinb[0]), .doutb(doutb[0]),
    .rstb_busy(rstb_busy), .dbg_state(dbg_state[0])
  );

  bram_lsu_bridge #(.MEM_BYTES(262144), .RD_LATENCY(2)) u_dut1 (
    .clkb(clkb), .rstb(rstb), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .enb(enb[1]), .web(web[1]), .addrb(addrb[1]), .dinb(dinb[1]), .doutb(doutb[1]),
    .rstb_busy(rstb_busy), .dbg_state(dbg_state[1])
  );

  // BRAM port B models: instance 0 without, instance 1 with an output register.
  for (genvar g = 0; g < 2; g++) begin : g_bram
    logic [31:0] mem [256];
    logic [31:0] rd1;
    logic [31:0] rd2;
    initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      rd1 <= 32'h0;
      rd2 <= 32'h0;
    end
    always @(posedge clkb) begin
      if (enb[g]) begin
        if (web[g][0]) mem[addrb[g][9:2]][7:0]   <= dinb[g][7:0];
        if (web[g][1]) mem[addrb[g][9:2]][15:8]  <= dinb[g][15:8];
        if (web[g][2]) mem[addrb[g][9:2]][23:16] <= dinb[g][23:16];
        if (web[g][3]) mem[addrb[g][9:2]][31:24] <= dinb[g][31:24];
        rd1 <= mem[addrb[g][9:2]];
      end
      rd2 <= rd1;
    end
    assign doutb[g] = (g == 0) ? rd1 : rd2;
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [3:0] exp_web_f(input logic we, input logic [1:0] size, input logic [1:0] o);
    if (!we) return 4'b0000;
    case (size)
      2'b00:   return 4'b0001 << o;
      2'b01:   return 4'b0011 << o;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_dinb_f(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Little-endian byte memory reference for loads.
  function automatic logic [31:0] model_load(input int d, input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
    int a;
    logic [31:0] w;
    a = int'(addr[9:0]);
    case (size)
      2'b00: begin
        w = {24'h0, ref_mem[d][a]};
        if (!uns && w[7]) w[31:8] = '1;
      end
      2'b01: begin
        w = {16'h0, ref_mem[d][a+1], ref_mem[d][a]};
        if (!uns && w[15]) w[31:16] = '1;
      end
      default: w = {ref_mem[d][a+3], ref_mem[d][a+2], ref_mem[d][a+1], ref_mem[d][a]};
    endcase
    return w;
  endfunction

  task automatic do_req(input int d, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input logic busy_mid);
    int k, lat, enb_cnt, enb_k, exp_lat, a;
    logic [3:0]  seen_web;
    logic [31:0] seen_addrb, seen_dinb;
    logic [32:0] exp_rsp;
    seen_web = 4'h0; seen_addrb = 32'h0; seen_dinb = 32'h0;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid[d] = 1'b1;
    #1;
    n_vec++;
    if (req_ready[d] !== 1'b1) begin
      n_err++;
      $display("FAIL req_ready dut%0d addr=%h: got %b want 1", d, addr, req_ready[d]);
    end
    exp_q.push_back({exp_err, exp_rdata});
    exp_lat = exp_err ? 1 : (we ? 2 : 2 + lat_of(d));
    if (!exp_err && we) begin
      a = int'(addr[9:0]);
      ref_mem[d][a] = wdata[7:0];
      if (size != 2'b00) ref_mem[d][a+1] = wdata[15:8];
      if (size == 2'b10) begin
        ref_mem[d][a+2] = wdata[23:16];
        ref_mem[d][a+3] = wdata[31:24];
      end
    end
    @(posedge clkb);
    @(negedge clkb);
    req_valid[d] = 1'b0;
    if (busy_mid) rstb_busy = 1'b1;
    k = 1; lat = 0; enb_cnt = 0; enb_k = 0;
    while (lat == 0 && k <= TIMEOUT) begin
      if (enb[d] === 1'b1) begin
        enb_cnt++;
        if (enb_k == 0) enb_k = k;
        seen_web = web[d]; seen_addrb = addrb[d]; seen_dinb = dinb[d];
      end
      if (rsp_valid[d] === 1'b1) lat = k;
      else begin
        @(negedge clkb);
        k++;
      end
    end
    rstb_busy = 1'b0;
    exp_rsp = exp_q.pop_front();
    n_vec++;
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL rsp_latency dut%0d addr=%h: got %0d want %0d (0 = none)", d, addr, lat, exp_lat);
    end
    if (lat != 0) begin
      n_vec++;
      if (rsp_rdata[d] !== exp_rsp[31:0]) begin
        n_err++;
        $display("FAIL rsp_rdata dut%0d addr=%h size=%0d: got %h want %h", d, addr, size, rsp_rdata[d], exp_rsp[31:0]);
      end
      n_vec++;
      if (rsp_err[d] !== exp_rsp[32]) begin
        n_err++;
        $display("FAIL rsp_err dut%0d addr=%h: got %b want %b", d, addr, rsp_err[d], exp_rsp[32]);
      end
    end
    n_vec++;
    if (enb_cnt != (exp_err ? 0 : 1)) begin
      n_err++;
      $display("FAIL enb_pulses dut%0d addr=%h: got %0d want %0d", d, addr, enb_cnt, exp_err ? 0 : 1);
    end
    if (!exp_err && enb_cnt == 1) begin
      n_vec++;
      if (enb_k != 1 || seen_web !== exp_web_f(we, size, addr[1:0]) || seen_addrb !== {addr[31:2], 2'b00}) begin
        n_err++;
        $display("FAIL bram_cmd dut%0d addr=%h: got cyc=%0d web=%b addrb=%h want cyc=1 web=%b addrb=%h",
                 d, addr, enb_k, seen_web, seen_addrb, exp_web_f(we, size, addr[1:0]), {addr[31:2], 2'b00});
      end
      if (we) begin
        n_vec++;
        if (seen_dinb !== exp_dinb_f(size, wdata)) begin
          n_err++;
          $display("FAIL dinb dut%0d addr=%h: got %h want %h", d, addr, seen_dinb, exp_dinb_f(size, wdata));
        end
      end
    end
    if (lat != 0) begin
      @(negedge clkb);
      n_vec++;
      if (rsp_valid[d] !== 1'b0 || dbg_state[d] !== ST_IDLE) begin
        n_err++;
        $display("FAIL rsp_release dut%0d: got valid=%b state=%0d want valid=0 state=0", d, rsp_valid[d], dbg_state[d]);
      end
    end
  endtask

  task automatic test_reset();
    rstb = 1'b1; rstb_busy = 1'b0; rsp_ready = 1'b1;
    repeat (10) begin
      @(negedge clkb);
      n_vec++;
      if (req_ready[0] !== 1'b0 || req_ready[1] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_req_ready: got %b%b want 00", req_ready[0], req_ready[1]);
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if ({rsp_valid[d], rsp_rdata[d], rsp_err[d], enb[d], web[d], addrb[d], dinb[d], dbg_state[d]} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: valid=%b rdata=%h err=%b enb=%b web=%b addrb=%h dinb=%h state=%0d want all 0",
                 d, rsp_valid[d], rsp_rdata[d], rsp_err[d], enb[d], web[d], addrb[d], dinb[d], dbg_state[d]);
      end
    end
    rstb_busy = 1'b1; rstb = 1'b0;
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0; req_valid[0] = 1'b1;
    repeat (4) begin
      #1;
      n_vec++;
      if (req_ready[0] !== 1'b0 || enb[0] !== 1'b0 || dbg_state[0] !== ST_IDLE) begin
        n_err++;
        $display("FAIL busy_blocks: got ready=%b enb=%b state=%0d want 0 0 0", req_ready[0], enb[0], dbg_state[0]);
      end
      @(negedge clkb);
    end
    req_valid[0] = 1'b0; rstb_busy = 1'b0;
    #1;
    n_vec++;
    if (req_ready[0] !== 1'b1) begin
      n_err++;
      $display("FAIL busy_release: got req_ready=%b want 1", req_ready[0]);
    end
    @(negedge clkb);
  endtask

  task automatic test_word(input int d);
    do_req(d, 1'b1, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    do_req(d, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
  endtask

  task automatic test_subword(input int d);
    do_req(d, 1'b1, 2'b10, 1'b0, 32'h4, 32'h12345678, 32'h0, 1'b0, 1'b0);
    do_req(d, 1'b1, 2'b00, 1'b0, 32'h5, 32'h000000F0, 32'h0, 1'b0, 1'b0);
    do_req(d, 1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 32'hFFFFFFF0, 1'b0, 1'b1);
    do_req(d, 1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 32'h000000F0, 1'b0, 1'b0);
    do_req(d, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'h00001234, 1'b0, 1'b0);
    do_req(d, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h1234F078, 1'b0, 1'b0);
    do_req(d, 1'b0, 2'b01, 1'b0, 32'h4, 32'h0, 32'hFFFFF078, 1'b0, 1'b0);
    do_req(d, 1'b0, 2'b01, 1'b1, 32'h4, 32'h0, 32'h0000F078, 1'b0, 1'b0);
    do_req(d, 1'b1, 2'b01, 1'b0, 32'hA, 32'h5555BEEF, 32'h0, 1'b0, 1'b1);
    do_req(d, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hBEEF0000, 1'b0, 1'b0);
  endtask

  task automatic test_errors(input int d);
    do_req(d, 1'b0, 2'b10, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1, 1'b0);
    do_req(d, 1'b0, 2'b01, 1'b0, 32'h9, 32'h0, 32'h0, 1'b1, 1'b0);
    do_req(d, 1'b0, 2'b10, 1'b0, 32'h40000, 32'h0, 32'h0, 1'b1, 1'b0);
    do_req(d, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    do_req(d, 1'b1, 2'b10, 1'b0, 32'h2, 32'hAAAAAAAA, 32'h0, 1'b1, 1'b0);
    do_req(d, 1'b1, 2'b00, 1'b0, 32'h40001, 32'h000000AA, 32'h0, 1'b1, 1'b0);
    do_req(d, 1'b0, 2'b10, 1'b0, 32'h3FFFC, 32'h0, 32'h0, 1'b0, 1'b0);
    do_req(d, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure(input int d);
    int k, enb_cnt;
    logic [32:0] exp_rsp;
    rsp_ready = 1'b0;
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0; req_valid[d] = 1'b1;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    @(posedge clkb);
    @(negedge clkb);
    req_addr = 32'h4;
    k = 1; enb_cnt = 0;
    while (rsp_valid[d] !== 1'b1 && k <= TIMEOUT) begin
      if (enb[d] === 1'b1) enb_cnt++;
      @(negedge clkb);
      k++;
    end
    n_vec++;
    if (rsp_valid[d] !== 1'b1) begin
      n_err++;
      $display("FAIL bp_rsp_timeout dut%0d: got rsp_valid=%b want 1", d, rsp_valid[d]);
    end else begin
      exp_rsp = exp_q.pop_front();
      repeat (5) begin
        n_vec++;
        if (rsp_valid[d] !== 1'b1 || {rsp_err[d], rsp_rdata[d]} !== exp_rsp || req_ready[d] !== 1'b0 || enb[d] !== 1'b0) begin
          n_err++;
          $display("FAIL bp_hold dut%0d: got valid=%b err=%b rdata=%h ready=%b enb=%b want 1 %b %h 0 0",
                   d, rsp_valid[d], rsp_err[d], rsp_rdata[d], req_ready[d], enb[d], exp_rsp[32], exp_rsp[31:0]);
        end
        @(negedge clkb);
      end
    end
    req_valid[d] = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clkb);
    n_vec++;
    if (rsp_valid[d] !== 1'b0 || dbg_state[d] !== ST_IDLE || enb_cnt != 1) begin
      n_err++;
      $display("FAIL bp_release dut%0d: got valid=%b state=%0d enb_pulses=%0d want 0 0 1", d, rsp_valid[d], dbg_state[d], enb_cnt);
    end
  endtask

  task automatic test_reset_abort(input int d);
    int k, stray;
    rsp_ready = 1'b1;
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h4; req_valid[d] = 1'b1;
    @(posedge clkb);
    @(negedge clkb);
    req_valid[d] = 1'b0;
    k = 1;
    while (dbg_state[d] !== ST_WAIT && k <= TIMEOUT) begin
      @(negedge clkb);
      k++;
    end
    n_vec++;
    if (dbg_state[d] !== ST_WAIT) begin
      n_err++;
      $display("FAIL abort_reach_wait dut%0d: got state=%0d want %0d", d, dbg_state[d], ST_WAIT);
    end
    rstb = 1'b1;
    @(posedge clkb);
    @(negedge clkb);
    n_vec++;
    if ({dbg_state[d], rsp_valid[d], enb[d]} !== '0) begin
      n_err++;
      $display("FAIL abort_state dut%0d: got state=%0d valid=%b enb=%b want 0 0 0", d, dbg_state[d], rsp_valid[d], enb[d]);
    end
    rstb = 1'b0;
    stray = 0;
    repeat (8) begin
      @(negedge clkb);
      if (rsp_valid[d] === 1'b1) stray++;
    end
    n_vec++;
    if (stray != 0) begin
      n_err++;
      $display("FAIL abort_no_rsp dut%0d: got %0d response cycles want 0", d, stray);
    end
    do_req(d, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h1234F078, 1'b0, 1'b0);
  endtask

  task automatic test_random(input int d, input int n);
    logic        we, uns, bad;
    logic [1:0]  size;
    logic [31:0] addr, wdata, exp_rd;
    for (int i = 0; i < n; i++) begin
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'b01) addr[0] = 1'b0;
        if (size == 2'b10) addr[1:0] = 2'b00;
      end
      if ($urandom_range(0, 9) == 0) addr = 32'h40000 + 32'($urandom_range(0, 255));
      wdata = $urandom();
      bad   = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'd262144);
      exp_rd = (bad || we) ? 32'h0 : model_load(d, size, uns, addr);
      do_req(d, we, size, uns, addr, wdata, exp_rd, bad, 1'(i % 5 == 0));
    end
  endtask

  initial begin
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 1024; i++) ref_mem[d][i] = 8'h0;
    test_reset();
    test_word(0);
    test_subword(0);
    test_errors(0);
    test_backpressure(0);
    test_reset_abort(0);
    test_random(0, 40);
    test_word(1);
    test_subword(1);
    test_backpressure(1);
    test_reset_abort(1);
    test_random(1, 30);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
